lcd_text_sequencer: RTL and testbench

LCD_TEXT_SEQUENCER -- requirements
Module: lcd_text_sequencer

---
 rtl/lcd_text_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_lcd_text_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_sequencer.sv
// Purpose: turns keyboard characters into LCD driver command words and tracks the cursor (row 0..1, col 0..15).
// Latency: an accepted character issues its first lcd_cmd pulse the next cycle; later steps wait for the driver's busy/done handshake.
// Backpressure: char_ready is high only in IDLE; the driver paces the sequencer through lcd_busy.
//
// Ports:
//   clock, internal_reset_n      : system clock, async active-low reset
//   char_in/char_valid/char_ready: character input handshake
//   lcd_busy                     : driver busy flag
//   lcd_cmd/lcd_cmd_valid        : {rs, data} word and its one-cycle strobe
//   cur_row/cur_col              : current cursor position
module lcd_text_sequencer #(
    parameter int ACK_TIMEOUT = 8,
    parameter int SYNC_CYCLES = 4
) (
    input  logic       clock,
    input  logic       internal_reset_n,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    input  logic       lcd_busy,
    output logic [8:0] lcd_cmd,
    output logic       lcd_cmd_valid,
    output logic       cur_row,
    output logic [3:0] cur_col
);

    localparam logic [2:0] S_SYNC      = 3'd0;
    localparam logic [2:0] S_IDLE      = 3'd1;
    localparam logic [2:0] S_ISSUE     = 3'd2;
    localparam logic [2:0] S_WAIT_ACK  = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;

    localparam int          CNT_W     = 16;
    localparam logic [8:0]  CMD_CLEAR = 9'h001;
    localparam logic [8:0]  CMD_SPACE = 9'h120;

    logic [2:0]       state;
    // Shared counter: consecutive busy-low cycles in SYNC, ack wait cycles in WAIT_ACK.
    logic [CNT_W-1:0] cnt;
    logic [2:0][8:0]  steps;
    logic [1:0]       step_len;
    logic [1:0]       step_idx;
    logic [8:0]       cmd_q;
    logic             row_q;
    logic [3:0]       col_q;

    logic [2:0][8:0]  dec_steps;
    logic [1:0]       dec_len;
    logic             dec_row;
    logic [3:0]       dec_col;

    // Set-DDRAM-address command, rs=0; row 1 starts at 0x40.
    function automatic logic [8:0] lcd_addr(input logic r, input logic [3:0] c);
        return {2'b01, r, 2'b00, c};
    endfunction

    // Character decode: the step list and the cursor position after this character.
    always_comb begin
        dec_steps = '0;
        dec_len   = 2'd0;
        dec_row   = row_q;
        dec_col   = col_q;
        if (char_in >= 8'h20 && char_in <= 8'h7E) begin
            dec_steps[0] = {1'b1, char_in};
            if (col_q == 4'd15) begin
                // The driver's auto-increment does not wrap onto the other row, so
                // follow the character with an explicit move.
                dec_col      = 4'd0;
                dec_row      = ~row_q;
                dec_steps[1] = lcd_addr(~row_q, 4'd0);
                dec_len      = 2'd2;
            end else begin
                dec_col = col_q + 4'd1;
                dec_len = 2'd1;
            end
        end else begin
            case (char_in)
                8'h0D: begin
                    dec_row      = ~row_q;
                    dec_col      = 4'd0;
                    dec_steps[0] = lcd_addr(~row_q, 4'd0);
                    dec_len      = 2'd1;
                end
                8'h08: begin
                    // Move back, blank the cell, then move back again so the
                    // cursor sits on the erased cell.
                    if (col_q != 4'd0) begin
                        dec_col      = col_q - 4'd1;
                        dec_steps[0] = lcd_addr(row_q, col_q - 4'd1);
                        dec_steps[1] = CMD_SPACE;
                        dec_steps[2] = lcd_addr(row_q, col_q - 4'd1);
                        dec_len      = 2'd3;
                    end else if (row_q) begin
                        dec_row      = 1'b0;
                        dec_col      = 4'd15;
                        dec_steps[0] = lcd_addr(1'b0, 4'd15);
                        dec_steps[1] = CMD_SPACE;
                        dec_steps[2] = lcd_addr(1'b0, 4'd15);
                        dec_len      = 2'd3;
                    end
                end
                8'h1B: begin
                    dec_row      = 1'b0;
                    dec_col      = 4'd0;
                    dec_steps[0] = CMD_CLEAR;
                    dec_len      = 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge internal_reset_n) begin
        if (!internal_reset_n) begin
            state    <= S_SYNC;
            cnt      <= '0;
            steps    <= '0;
            step_len <= 2'd0;
            step_idx <= 2'd0;
            cmd_q    <= 9'h000;
            row_q    <= 1'b0;
            col_q    <= 4'd0;
        end else begin
            case (state)
                S_SYNC: begin
                    if (lcd_busy) begin
                        cnt <= '0;
                    end else if (cnt == CNT_W'(SYNC_CYCLES - 1)) begin
                        steps[0] <= CMD_CLEAR;
                        step_len <= 2'd1;
                        step_idx <= 2'd0;
                        row_q    <= 1'b0;
                        col_q    <= 4'd0;
                        cnt      <= '0;
                        state    <= S_ISSUE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    // char_ready is implied by being in IDLE.
                    if (char_valid) begin
                        row_q    <= dec_row;
                        col_q    <= dec_col;
                        steps    <= dec_steps;
                        step_len <= dec_len;
                        step_idx <= 2'd0;
                        if (dec_len != 2'd0) state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cmd_q <= steps[step_idx];
                    cnt   <= '0;
                    state <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (lcd_busy) begin
                        state <= S_WAIT_DONE;
                    end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                        // Driver never acknowledged: drop the rest and resync.
                        step_len <= 2'd0;
                        step_idx <= 2'd0;
                        cnt      <= '0;
                        state    <= S_SYNC;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!lcd_busy) begin
                        if ((step_idx + 2'd1) < step_len) begin
                            step_idx <= step_idx + 2'd1;
                            state    <= S_ISSUE;
                        end else begin
                            step_len <= 2'd0;
                            state    <= S_IDLE;
                        end
                    end
                end
                default: state <= S_SYNC;
            endcase
        end
    end

    assign char_ready    = (state == S_IDLE);
    assign lcd_cmd_valid = (state == S_ISSUE);
    // The word is live during ISSUE and held in cmd_q afterwards.
    assign lcd_cmd       = lcd_cmd_valid ? steps[step_idx] : cmd_q;
    assign cur_row       = row_q;
    assign cur_col       = col_q;

endmodule

// File: tb/tb_lcd_text_sequencer.sv
// Purpose: self-checking bench for lcd_text_sequencer with a behavioural LCD driver and command scoreboard.
// Latency: the driver raises busy two cycles after each pulse and holds it for three cycles.
// Backpressure: characters are sent only while char_ready is high.
module tb_lcd_text_sequencer;

    logic       clock;
    logic       internal_reset_n;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;
    logic       lcd_busy;
    logic [8:0] lcd_cmd;
    logic       lcd_cmd_valid;
    logic       cur_row;
    logic [3:0] cur_col;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [8:0] exp_q[$];
    logic       drv_ack;
    logic       m_row;
    logic [3:0] m_col;

    lcd_text_sequencer #(.ACK_TIMEOUT(8), .SYNC_CYCLES(4)) dut (
        .clock            (clock),
        .internal_reset_n (internal_reset_n),
        .char_in          (char_in),
        .char_valid       (char_valid),
        .char_ready       (char_ready),
        .lcd_busy         (lcd_busy),
        .lcd_cmd          (lcd_cmd),
        .lcd_cmd_valid    (lcd_cmd_valid),
        .cur_row          (cur_row),
        .cur_col          (cur_col)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] tb_addr(input logic r, input logic [3:0] c);
        return 9'h080 | (r ? 9'h040 : 9'h000) | {5'b0, c};
    endfunction

    // Reference model: expected command words and cursor after one character.
    task automatic tb_model(input logic [7:0] c);
        if (c >= 8'h20 && c <= 8'h7E) begin
            exp_q.push_back({1'b1, c});
            if (m_col == 4'd15) begin
                m_col = 4'd0;
                m_row = ~m_row;
                exp_q.push_back(tb_addr(m_row, 4'd0));
            end else begin
                m_col = m_col + 4'd1;
            end
        end else if (c == 8'h0D) begin
            m_row = ~m_row;
            m_col = 4'd0;
            exp_q.push_back(tb_addr(m_row, m_col));
        end else if (c == 8'h08) begin
            if (m_col != 4'd0 || m_row) begin
                if (m_col != 4'd0) m_col = m_col - 4'd1;
                else begin m_row = 1'b0; m_col = 4'd15; end
                exp_q.push_back(tb_addr(m_row, m_col));
                exp_q.push_back(9'h120);
                exp_q.push_back(tb_addr(m_row, m_col));
            end
        end else if (c == 8'h1B) begin
            exp_q.push_back(9'h001);
            m_row = 1'b0;
            m_col = 4'd0;
        end
    endtask

    // Behavioural driver: acknowledges each pulse with a busy window.
    initial begin
        forever begin
            @(negedge clock);
            if (lcd_cmd_valid && drv_ack) begin
                repeat (2) @(negedge clock);
                lcd_busy = 1'b1;
                repeat (3) @(negedge clock);
                lcd_busy = 1'b0;
            end
        end
    end

    // Scoreboard monitor: every pulse must match the head of the expected queue.
    initial begin
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clock);
            if (lcd_cmd_valid) begin
                chk_val("pulse_width", prev_valid, 0);
                if (exp_q.size() == 0) chk_val("pulse_extra", lcd_cmd_valid, 0);
                else chk_val("pulse_cmd", lcd_cmd, exp_q.pop_front());
            end
            prev_valid = lcd_cmd_valid;
        end
    end

    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        @(negedge clock);
        while (!char_ready && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (!char_ready) chk_val("ready_timeout", char_ready, 1);
    endtask

    task automatic send_char(input logic [7:0] c);
        wait_ready(200);
        char_in    = c;
        char_valid = 1'b1;
        tb_model(c);
        @(posedge clock);
        #1 char_valid = 1'b0;
        @(negedge clock);
        chk_val("cur_row", cur_row, m_row);
        chk_val("cur_col", cur_col, m_col);
    endtask

    task automatic settle(input string tag);
        wait_ready(200);
        chk_val(tag, exp_q.size(), 0);
        chk_val("idle_row", cur_row, m_row);
        chk_val("idle_col", cur_col, m_col);
    endtask

    initial begin
        int n;
        internal_reset_n = 1'b0;
        char_in    = 8'h00;
        char_valid = 1'b0;
        lcd_busy   = 1'b1;
        drv_ack    = 1'b1;
        m_row      = 1'b0;
        m_col      = 4'd0;

        repeat (3) @(negedge clock);
        chk_val("rst_ready", char_ready, 0);
        chk_val("rst_valid", lcd_cmd_valid, 0);
        chk_val("rst_cmd", lcd_cmd, 9'h000);
        chk_val("rst_row", cur_row, 0);
        chk_val("rst_col", cur_col, 0);

        // Power-on: driver busy for 1000 cycles, then the clear after 4 low cycles.
        internal_reset_n = 1'b1;
        repeat (1000) @(negedge clock);
        chk_val("ready_while_busy", char_ready, 0);
        exp_q.push_back(9'h001);
        lcd_busy = 1'b0;
        n = 0;
        while (!lcd_cmd_valid && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk_val("sync_latency", n, 4);
        settle("poweron_q");

        // 'A' at row0 col3.
        send_char("x");
        send_char("y");
        send_char("z");
        send_char(8'h41);
        settle("char_a_q");
        chk_val("cmd_hold", lcd_cmd, 9'h141);

        // 16 characters from the home position wrap to row 1.
        send_char(8'h1B);
        for (int i = 0; i < 16; i++) send_char(8'h61 + 8'(i));
        settle("wrap_q");

        // Backspace across the row boundary, then within a row.
        send_char(8'h08);
        settle("bs_row1_q");
        send_char(8'h08);
        settle("bs_mid_q");

        // Enter, an unknown code, and a backspace at home (no-op).
        send_char(8'h0D);
        send_char(8'h07);
        settle("enter_q");
        send_char(8'h1B);
        send_char(8'h08);
        settle("bs_home_q");

        // Ack timeout: the driver ignores the first backspace step.
        for (int i = 0; i < 5; i++) send_char(8'h31 + 8'(i));
        settle("pre_to_q");
        drv_ack = 1'b0;
        send_char(8'h08);
        chk_val("to_first_pulse", lcd_cmd_valid, 1);
        @(negedge clock);
        n = 1;
        drv_ack = 1'b1;
        exp_q.delete();
        exp_q.push_back(9'h001);
        m_row = 1'b0;
        m_col = 4'd0;
        while (!lcd_cmd_valid && n < 60) begin
            @(negedge clock);
            n++;
        end
        chk_val("timeout_gap", n, 13);
        settle("timeout_q");

        // Reset during WAIT_DONE of a 3-step backspace.
        send_char(8'h0D);
        settle("pre_rst_q");
        send_char(8'h08);
        n = 0;
        while (!lcd_busy && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!lcd_busy) chk_val("busy_wait", lcd_busy, 1);
        @(negedge clock);
        internal_reset_n = 1'b0;
        #1;
        chk_val("mid_rst_ready", char_ready, 0);
        chk_val("mid_rst_valid", lcd_cmd_valid, 0);
        chk_val("mid_rst_cmd", lcd_cmd, 9'h000);
        chk_val("mid_rst_row", cur_row, 0);
        chk_val("mid_rst_col", cur_col, 0);
        exp_q.delete();
        exp_q.push_back(9'h001);
        m_row = 1'b0;
        m_col = 4'd0;
        repeat (3) @(negedge clock);
        internal_reset_n = 1'b1;
        settle("resync_q");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
